ysyx_23060187_pcgen: RTL and testbench
======================================

# ysyx_23060187_pcgen

Parametrised next-generation PC generator for the NPC core front end. Holds the fetch PC and offers it to the IFU over a valid/ready handshake. Resolves branch/jump outcomes from the EXU with stale-result filtering by epoch, and applies trap/mret redirects with fixed priority. Detects misaligned control-flow targets and parks fetch until the trap arrives.

## Interface
Parameters:
- XLEN, 32: PC / operand width.
- RESET_VEC, 32'h8000_0000: PC presented after reset.
- EPOCH_W, 2: width of the redirect epoch tag.
- IALIGN, 32: instruction alignment in bits, 32 or 16. It sets the misalignment check; the sequential increment is always 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pc_valid  out  1  pc_out offered to IFU.
- pc_ready  in  1  IFU accepts pc_out.
- pc_out  out  XLEN  fetch address.
- pc_epoch  out  EPOCH_W  epoch tag travelling with pc_out.
- br_valid  in  1  EXU resolution present this cycle.
- br_is_jal, br_is_jalr, br_is_branch  in  1 each  one-hot control-flow kind.
- br_funct3  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- br_pc, br_imm, br_src1, br_src2  in  XLEN each  instruction PC, immediate, rs1, rs2.
- br_epoch  in  EPOCH_W  epoch of the resolving instruction.
- trap_valid, trap_vec  in  1 / XLEN  trap redirect to mtvec target.
- mret_valid, mepc  in  1 / XLEN  return redirect.
- misalign_err  out  1  one-cycle pulse.
- misalign_addr  out  XLEN  offending target, held until the next pulse.

## Operation
- FSM states:
  - BOOT: entered on reset.
  - RUN
  - TRAP_WAIT
- Reset values:
  - pc_out = RESET_VEC, pc_valid = 0, pc_epoch = 0, misalign_err = 0, misalign_addr = 0, state BOOT.
- BOOT -> RUN unconditionally on the first clock edge after rst deasserts. pc_valid = 1 in RUN only.
- RUN, no redirect: on pc_valid && pc_ready, pc_out <= pc_out + 4. Otherwise pc_out holds.
- A resolution is live only when br_valid && br_epoch == pc_epoch. Stale resolutions are ignored entirely, with no redirect and no error.
- Targets:
  - jal / taken branch: br_pc + br_imm.
  - jalr: (br_src1 + br_imm) & ~1.
  - All sums are modulo 2^XLEN.
- Taken: jal and jalr always. Branches follow br_funct3 with signed compares for BLT/BGE and unsigned for BLTU/BGEU. Not-taken branches cause no action.
- Misaligned target: target[1] set (IALIGN 32) or target[0] set (IALIGN 16, impossible after jalr masking).
  - Effect: no PC change, misalign_err pulses, misalign_addr = target, state -> TRAP_WAIT.
- TRAP_WAIT: pc_valid = 0. Only trap_valid leaves it; mret and resolutions are ignored.
- Redirect priority in any state except BOOT: trap_valid > mret_valid > live taken resolution.
  - The winner loads pc_out, increments pc_epoch (wrapping) and enters RUN.
  - This overrides a same-cycle handshake advance. The accepted pc_out of that cycle still counts as fetched.
- Illegal one-hot kind (more than one set): treat as no resolution.

## Timing
- Redirect latency 1 cycle: redirect sampled at edge N, new pc_out and pc_epoch visible after N, with pc_valid = 1.
- misalign_err asserted the cycle after the live misaligned resolution, for exactly one cycle.
- pc_out and pc_epoch stable while pc_valid && !pc_ready, unless a redirect wins.
- Simultaneous trap + misaligned resolution: trap wins, no misalign_err.
- rst asserted mid-operation returns immediately to reset values, regardless of clk.
- PC wrap: all-ones minus 3 + 4 -> 0, no flag.

## Structure
- Shared package / header holds:
  - funct3 branch encodings
  - FSM state encodings
  - ILEN constant 4
- Sub-module ysyx_23060187_brcond: combinational, takes funct3 and src1/src2, outputs taken. It is reused by any later branch predictor checker.
- Target adders, priority mux and FSM live in the top.

## Test plan
- Reset, then pc_ready = 1 for 3 cycles:
  - pc_valid = 0 in the first cycle.
  - Then pc_out = 0x80000000, 0x80000004, 0x80000008.
  - pc_epoch = 0 throughout.
- pc_ready = 0 for 4 cycles at 0x80000010: pc_out holds 0x80000010, then advances only after ready rises.
- Live BNE with src1 = 5, src2 = 6, br_pc = 0x80000020, imm = 0x40: next cycle pc_out = 0x80000060, epoch 1.
- Same BNE with br_epoch = 0 after that: ignored. BEQ with src1 = src2 = 3, live: redirect to br_pc + imm.
- jalr with src1 = 0x80001003, imm = 0: target 0x80001002.
  - IALIGN 32: misalign_err pulse with misalign_addr = 0x80001002; pc_valid = 0 until trap_valid with trap_vec = 0x80000100, then pc_out = 0x80000100.
  - IALIGN 16: redirect to 0x80001002.
- Same-cycle trap_valid (vec 0x80000100), mret_valid (mepc 0x80000200) and live jal: pc_out = 0x80000100. Epoch increments once.
- Assert rst mid-redirect: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ysyx_23060187_pcgen_pkg.sv
// Shared definitions for the PC generator and its branch-condition helper.
package ysyx_23060187_pcgen_pkg;

  localparam int unsigned ILEN = 4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_TRAP_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_23060187_brcond.sv
// Combinational branch-condition evaluator; undefined funct3 values are not taken.
module ysyx_23060187_brcond
  import ysyx_23060187_pcgen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (src1 == src2);
      F3_BNE:  taken = (src1 != src2);
      F3_BLT:  taken = ($signed(src1) <  $signed(src2));
      F3_BGE:  taken = ($signed(src1) >= $signed(src2));
      F3_BLTU: taken = (src1 <  src2);
      F3_BGEU: taken = (src1 >= src2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060187_pcgen.sv
// Fetch PC generator: sequential advance, epoch-filtered branch redirects,
// trap/mret redirects, and misaligned-target parking until a trap arrives.
module ysyx_23060187_pcgen
  import ysyx_23060187_pcgen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 'h8000_0000,
  parameter int unsigned     EPOCH_W   = 2,
  parameter int unsigned     IALIGN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pc_valid,
  input  logic               pc_ready,
  output logic [XLEN-1:0]    pc_out,
  output logic [EPOCH_W-1:0] pc_epoch,
  input  logic               br_valid,
  input  logic               br_is_jal,
  input  logic               br_is_jalr,
  input  logic               br_is_branch,
  input  logic [2:0]         br_funct3,
  input  logic [XLEN-1:0]    br_pc,
  input  logic [XLEN-1:0]    br_imm,
  input  logic [XLEN-1:0]    br_src1,
  input  logic [XLEN-1:0]    br_src2,
  input  logic [EPOCH_W-1:0] br_epoch,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vec,
  input  logic               mret_valid,
  input  logic [XLEN-1:0]    mepc,
  output logic               misalign_err,
  output logic [XLEN-1:0]    misalign_addr
);

  state_t              state, state_n;
  logic [XLEN-1:0]     pc_n, addr_n;
  logic [EPOCH_W-1:0]  epoch_n;
  logic                err_n;

  logic                cond_taken;
  logic                kind_ok, live, res_taken, misaligned;
  logic [XLEN-1:0]     sum_pc, sum_reg, target;

  ysyx_23060187_brcond #(.XLEN(XLEN)) u_brcond (
    .funct3 (br_funct3),
    .src1   (br_src1),
    .src2   (br_src2),
    .taken  (cond_taken)
  );

  assign kind_ok   = $onehot({br_is_jal, br_is_jalr, br_is_branch});
  assign live      = br_valid && (br_epoch == pc_epoch) && kind_ok;
  assign res_taken = live && (br_is_jal || br_is_jalr || (br_is_branch && cond_taken));

  assign sum_pc  = br_pc + br_imm;
  assign sum_reg = br_src1 + br_imm;
  assign target  = br_is_jalr ? {sum_reg[XLEN-1:1], 1'b0} : sum_pc;

  // 16-bit alignment can only fault on bit 0, which jalr has already cleared.
  assign misaligned = (IALIGN == 16) ? target[0] : target[1];

  assign pc_valid = (state == ST_RUN);

  always_comb begin
    state_n = state;
    pc_n    = pc_out;
    epoch_n = pc_epoch;
    err_n   = 1'b0;
    addr_n  = misalign_addr;
    case (state)
      ST_BOOT: state_n = ST_RUN;
      ST_RUN: begin
        if (trap_valid) begin
          pc_n    = trap_vec;
          epoch_n = pc_epoch + 1'b1;
        end else if (mret_valid) begin
          pc_n    = mepc;
          epoch_n = pc_epoch + 1'b1;
        end else if (res_taken) begin
          if (misaligned) begin
            err_n   = 1'b1;
            addr_n  = target;
            state_n = ST_TRAP_WAIT;
          end else begin
            pc_n    = target;
            epoch_n = pc_epoch + 1'b1;
          end
        end else if (pc_valid && pc_ready) begin
          pc_n = pc_out + XLEN'(ILEN);
        end
      end
      ST_TRAP_WAIT: begin
        if (trap_valid) begin
          pc_n    = trap_vec;
          epoch_n = pc_epoch + 1'b1;
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_BOOT;
      pc_out        <= RESET_VEC;
      pc_epoch      <= '0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state         <= state_n;
      pc_out        <= pc_n;
      pc_epoch      <= epoch_n;
      misalign_err  <= err_n;
      misalign_addr <= addr_n;
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_pcgen.sv
// Scoreboard bench: two DUTs (IALIGN 32 and 16) share stimulus; a behavioural
// model pushes expected outputs per edge and a negedge monitor pops and compares.
module tb_ysyx_23060187_pcgen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, ready, bv, jal, jalr, brb, tv, mv;
  logic [2:0]  f3;
  logic [31:0] bpc, bimm, s1, s2, tvec, mepc_i;
  logic [1:0]  bep;

  logic        v0, v1, err0, err1;
  logic [31:0] pc0, pc1, addr0, addr1;
  logic [1:0]  ep0, ep1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  ysyx_23060187_pcgen #(.XLEN(32), .RESET_VEC(RV), .EPOCH_W(2), .IALIGN(32)) u32 (
    .clk(clk), .rst(rst), .pc_valid(v0), .pc_ready(ready), .pc_out(pc0), .pc_epoch(ep0),
    .br_valid(bv), .br_is_jal(jal), .br_is_jalr(jalr), .br_is_branch(brb), .br_funct3(f3),
    .br_pc(bpc), .br_imm(bimm), .br_src1(s1), .br_src2(s2), .br_epoch(bep),
    .trap_valid(tv), .trap_vec(tvec), .mret_valid(mv), .mepc(mepc_i),
    .misalign_err(err0), .misalign_addr(addr0));

  ysyx_23060187_pcgen #(.XLEN(32), .RESET_VEC(RV), .EPOCH_W(2), .IALIGN(16)) u16 (
    .clk(clk), .rst(rst), .pc_valid(v1), .pc_ready(ready), .pc_out(pc1), .pc_epoch(ep1),
    .br_valid(bv), .br_is_jal(jal), .br_is_jalr(jalr), .br_is_branch(brb), .br_funct3(f3),
    .br_pc(bpc), .br_imm(bimm), .br_src1(s1), .br_src2(s2), .br_epoch(bep),
    .trap_valid(tv), .trap_vec(tvec), .mret_valid(mv), .mepc(mepc_i),
    .misalign_err(err1), .misalign_addr(addr1));

  typedef struct {
    bit          booted;
    bit          parked;
    logic [31:0] pc;
    logic [1:0]  ep;
    bit          err;
    logic [31:0] addr;
  } mdl_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic        err;
    logic [31:0] addr;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  mdl_t m[2];
  exp_t q[$];

  function automatic mdl_t mreset();
    mdl_t n;
    n.booted = 0; n.parked = 0; n.pc = RV; n.ep = 2'd0; n.err = 0; n.addr = 32'd0;
    return n;
  endfunction

  function automatic bit cond(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit a16);
    mdl_t n = s;
    logic [31:0] t;
    int nk;
    bit tk;
    n.err = 0;
    if (rst) return mreset();
    if (!s.booted) begin n.booted = 1; return n; end
    nk = int'(jal) + int'(jalr) + int'(brb);
    tk = jal || jalr || (brb && cond(f3, s1, s2));
    t  = jalr ? ((s1 + bimm) & ~32'd1) : (bpc + bimm);
    if (tv) begin
      n.pc = tvec; n.ep = s.ep + 2'd1; n.parked = 0;
    end else if (s.parked) begin
      n.parked = 1;
    end else if (mv) begin
      n.pc = mepc_i; n.ep = s.ep + 2'd1;
    end else if (bv && bep == s.ep && nk == 1 && tk) begin
      if (a16 ? t[0] : t[1]) begin
        n.err = 1; n.addr = t; n.parked = 1;
      end else begin
        n.pc = t; n.ep = s.ep + 2'd1;
      end
    end else if (ready) begin
      n.pc = s.pc + 32'd4;
    end
    return n;
  endfunction

  function automatic obs_t view(mdl_t s);
    obs_t o;
    o.v = s.booted && !s.parked; o.pc = s.pc; o.ep = s.ep; o.err = s.err; o.addr = s.addr;
    return o;
  endfunction

  task automatic chk(string nm, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got v=%b pc=%h ep=%0d err=%b addr=%h, want v=%b pc=%h ep=%0d err=%b addr=%h",
               nm, $time, act.v, act.pc, act.ep, act.err, act.addr,
               exp.v, exp.pc, exp.ep, exp.err, exp.addr);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares both DUTs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ialign32", {v0, pc0, ep0, err0, addr0}, e.a);
        chk("ialign16", {v1, pc1, ep1, err1, addr1}, e.b);
      end
    end
  end

  task automatic clr();
    bv = 0; jal = 0; jalr = 0; brb = 0; f3 = 3'd0; bpc = 0; bimm = 0; s1 = 0; s2 = 0; bep = 0;
    tv = 0; tvec = 0; mv = 0; mepc_i = 0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    m[0] = mstep(m[0], 1'b0);
    m[1] = mstep(m[1], 1'b1);
    e.a = view(m[0]);
    e.b = view(m[1]);
    q.push_back(e);
    #1;
  endtask

  task automatic branch(logic [2:0] f, logic [31:0] pc, logic [31:0] imm,
                        logic [31:0] a, logic [31:0] b, logic [1:0] ep);
    bv = 1; brb = 1; f3 = f; bpc = pc; bimm = imm; s1 = a; s2 = b; bep = ep;
    step();
    clr();
  endtask

  logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    obs_t rv;
    int unsigned r;
    rv.v = 0; rv.pc = RV; rv.ep = 0; rv.err = 0; rv.addr = 0;
    clr();
    ready = 0;
    rst = 1;
    m[0] = mreset();
    m[1] = mreset();
    #3;
    chk("reset32", {v0, pc0, ep0, err0, addr0}, rv);
    chk("reset16", {v1, pc1, ep1, err1, addr1}, rv);
    step();
    step();
    rst = 0;

    ready = 1;
    repeat (5) step();
    ready = 0;
    repeat (4) step();
    ready = 1;
    step();

    branch(3'd1, 32'h8000_0020, 32'h40, 32'd5, 32'd6, m[0].ep);
    branch(3'd1, 32'h8000_0020, 32'h40, 32'd5, 32'd6, 2'd0);
    branch(3'd0, 32'h8000_0020, 32'h40, 32'd3, 32'd3, m[0].ep);

    bv = 1; jalr = 1; s1 = 32'h8000_1003; bimm = 0; bep = m[0].ep;
    step();
    clr();
    repeat (3) step();
    mv = 1; mepc_i = 32'h8000_0200;
    bv = 1; jal = 1; bpc = 32'h8000_0300; bimm = 32'h10; bep = m[0].ep;
    step();
    clr();
    tv = 1; tvec = 32'h8000_0100;
    step();
    clr();

    tv = 1; tvec = 32'h8000_0100; mv = 1; mepc_i = 32'h8000_0200;
    bv = 1; jal = 1; bpc = 32'h8000_0400; bimm = 32'h8; bep = m[0].ep;
    step();
    clr();

    tv = 1; tvec = 32'hFFFF_FFFC;
    step();
    clr();
    step();

    for (int unsigned i = 0; i < 400; i++) begin
      clr();
      ready = ($urandom_range(0, 3) != 0);
      tv = ($urandom_range(0, 11) == 0);
      tvec = $urandom & ~32'd3;
      mv = ($urandom_range(0, 15) == 0);
      mepc_i = $urandom & ~32'd3;
      bv = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 7);
      if (r < 6) {jal, jalr, brb} = 3'b001 << (r % 3);
      else {jal, jalr, brb} = (r == 6) ? 3'b110 : 3'b111;
      f3 = f3s[$urandom_range(0, 5)];
      bpc = $urandom & ~32'd3;
      bimm = $urandom & ~32'd3;
      if ($urandom_range(0, 3) == 0) bimm = bimm | 32'd2;
      if ($urandom_range(0, 7) == 0) bimm = bimm | 32'd1;
      if ($urandom_range(0, 1) == 0) begin
        s1 = $urandom_range(0, 3); s2 = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) s1 = ~s1;
      end else begin
        s1 = $urandom; s2 = $urandom;
      end
      bep = ($urandom_range(0, 3) == 0) ? 2'($urandom) : m[0].ep;
      step();
    end

    clr();
    ready = 1;
    tv = 1; tvec = 32'h8000_0100;
    #5;
    rst = 1;
    #1;
    chk("async_rst32", {v0, pc0, ep0, err0, addr0}, rv);
    chk("async_rst16", {v1, pc1, ep1, err1, addr1}, rv);
    step();
    rst = 0;
    clr();
    repeat (4) step();

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
